// File: rtl/reg_writeback_pkg.sv
// reg_writeback_pkg
//   Shared types and default parameter values for the register-file
//   write-back arbiter (reg_writeback) and its load-result queue (wb_queue).
//   wb_src_e encodes which producer owns the current register-file write.
package reg_writeback_pkg;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_MEM  = 2'd2
    } wb_src_e;

    localparam int DEFAULT_DATA_WIDTH  = 8;
    localparam int DEFAULT_NUM_REGS    = 16;
    localparam int DEFAULT_QUEUE_DEPTH = 4;

endpackage

// File: rtl/wb_queue.sv
// wb_queue
//   In-order circular FIFO of pending load write-backs. Every entry carries a
//   live bit; a kill request clears live on every entry whose address matches,
//   so a newer ALU write can squash older queued loads to the same register.
//   Ports:
//     clk, rstN                  clock, asynchronous active-low reset
//     push, pushLive             enqueue an entry with the given live bit
//     pushAddr, pushData         entry contents
//     pop                        dequeue the head entry (caller ensures count>0)
//     killEn, killAddr           clear live on every entry addressed killAddr
//     headLive/headAddr/headData head entry view (combinational)
//     count, full                occupancy
//     liveMask                   one bit per register targeted by a live entry
import reg_writeback_pkg::*;

module wb_queue #(
    parameter int DataWidth  = DEFAULT_DATA_WIDTH,
    parameter int NumRegs    = DEFAULT_NUM_REGS,
    parameter int IndexWidth = $clog2(NumRegs),
    parameter int QueueDepth = DEFAULT_QUEUE_DEPTH,
    parameter int PtrWidth   = $clog2(QueueDepth),
    parameter int CountWidth = $clog2(QueueDepth) + 1
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic                  push,
    input  logic                  pushLive,
    input  logic [IndexWidth-1:0] pushAddr,
    input  logic [DataWidth-1:0]  pushData,
    input  logic                  pop,
    input  logic                  killEn,
    input  logic [IndexWidth-1:0] killAddr,
    output logic                  headLive,
    output logic [IndexWidth-1:0] headAddr,
    output logic [DataWidth-1:0]  headData,
    output logic [CountWidth-1:0] count,
    output logic                  full,
    output logic [NumRegs-1:0]    liveMask
);

    logic [PtrWidth-1:0]   headPtr;
    logic [PtrWidth-1:0]   tailPtr;
    logic [QueueDepth-1:0] liveBits;
    logic [IndexWidth-1:0] addrMem [QueueDepth];
    logic [DataWidth-1:0]  dataMem [QueueDepth];

    assign full     = (count == CountWidth'(QueueDepth));
    assign headLive = liveBits[headPtr];
    assign headAddr = addrMem[headPtr];
    assign headData = dataMem[headPtr];

    // Pointers wrap naturally because QueueDepth is a power of two.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
        end else begin
            if (push) tailPtr <= tailPtr + 1'b1;
            if (pop)  headPtr <= headPtr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset: an entry is only meaningful while live.
    always_ff @(posedge clk) begin
        if (push) begin
            addrMem[tailPtr] <= pushAddr;
            dataMem[tailPtr] <= pushData;
        end
    end

    // Per-entry live bit. A freshly pushed entry takes pushLive (the caller has
    // already folded in a same-cycle kill); popped or killed entries go dead,
    // which also keeps freed slots out of liveMask.
    genvar gi;
    generate
        for (gi = 0; gi < QueueDepth; gi++) begin : gEntry
            always_ff @(posedge clk or negedge rstN) begin
                if (!rstN) begin
                    liveBits[gi] <= 1'b0;
                end else if (push && tailPtr == PtrWidth'(gi)) begin
                    liveBits[gi] <= pushLive;
                end else if ((pop && headPtr == PtrWidth'(gi)) ||
                             (killEn && addrMem[gi] == killAddr)) begin
                    liveBits[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    always_comb begin
        liveMask = '0;
        for (int i = 0; i < QueueDepth; i++) begin
            if (liveBits[i]) liveMask[addrMem[i]] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback
//   Drives the register file's single write port from the ALU (always
//   accepted, highest priority) and the memory-load unit (valid/ready,
//   buffered in wb_queue). Queued loads drain into ALU-idle cycles; an ALU
//   write squashes every older queued load to the same register.
//   Optional feature: define REG_WRITEBACK_BYPASS_EN to let a load that
//   arrives with the queue empty and the ALU idle go straight to the output
//   register (1-cycle latency). Without it every load goes through the queue.
//   Ports:
//     clk, rstN                      clock, asynchronous active-low reset
//     aluValid/aluAddr/aluData       ALU result
//     memValid/memReady/memAddr/memData  load result handshake
//     writeEn/writeAddr/writeData    registered register-file write port
//     writeSrc                       owner of current write (wb_src_e)
//     pendingMask                    registers targeted by live queued loads
//     queueCount                     occupied queue entries
import reg_writeback_pkg::*;

module reg_writeback #(
    parameter int DataWidth  = DEFAULT_DATA_WIDTH,
    parameter int NumRegs    = DEFAULT_NUM_REGS,
    parameter int IndexWidth = $clog2(NumRegs),
    parameter int QueueDepth = DEFAULT_QUEUE_DEPTH
) (
    input  logic                         clk,
    input  logic                         rstN,
    input  logic                         aluValid,
    input  logic [IndexWidth-1:0]        aluAddr,
    input  logic [DataWidth-1:0]         aluData,
    input  logic                         memValid,
    output logic                         memReady,
    input  logic [IndexWidth-1:0]        memAddr,
    input  logic [DataWidth-1:0]         memData,
    output logic                         writeEn,
    output logic [IndexWidth-1:0]        writeAddr,
    output logic [DataWidth-1:0]         writeData,
    output logic [1:0]                   writeSrc,
    output logic [NumRegs-1:0]           pendingMask,
    output logic [$clog2(QueueDepth):0]  queueCount
);

    localparam int CountWidth = $clog2(QueueDepth) + 1;

    logic                  queueFull;
    logic                  headLive;
    logic [IndexWidth-1:0] headAddr;
    logic [DataWidth-1:0]  headData;
    logic                  memAccept;
    logic                  bypassTake;
    logic                  queuePush;
    logic                  queuePop;
    logic                  pushLive;
    wb_src_e               srcReg;

    // Ready depends on occupancy only; a same-cycle pop never frees a slot early.
    assign memReady  = !queueFull;
    assign memAccept = memValid && memReady;

`ifdef REG_WRITEBACK_BYPASS_EN
    assign bypassTake = memAccept && (queueCount == '0) && !aluValid;
`else
    assign bypassTake = 1'b0;
`endif

    assign queuePush = memAccept && !bypassTake;
    assign queuePop  = !aluValid && (queueCount != '0);
    // A load arriving alongside an ALU write to the same register is older,
    // so it completes the handshake but enters the queue already dead.
    assign pushLive  = !(aluValid && aluAddr == memAddr);

    wb_queue #(
        .DataWidth  (DataWidth),
        .NumRegs    (NumRegs),
        .IndexWidth (IndexWidth),
        .QueueDepth (QueueDepth),
        .PtrWidth   ($clog2(QueueDepth)),
        .CountWidth (CountWidth)
    ) uQueue (
        .clk      (clk),
        .rstN     (rstN),
        .push     (queuePush),
        .pushLive (pushLive),
        .pushAddr (memAddr),
        .pushData (memData),
        .pop      (queuePop),
        .killEn   (aluValid),
        .killAddr (aluAddr),
        .headLive (headLive),
        .headAddr (headAddr),
        .headData (headData),
        .count    (queueCount),
        .full     (queueFull),
        .liveMask (pendingMask)
    );

    // Output register: ALU first, then bypass, then queue head. A dead head
    // still consumes its cycle but produces no write.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            writeEn   <= 1'b0;
            writeAddr <= '0;
            writeData <= '0;
            srcReg    <= WB_NONE;
        end else if (aluValid) begin
            writeEn   <= 1'b1;
            writeAddr <= aluAddr;
            writeData <= aluData;
            srcReg    <= WB_ALU;
        end else if (bypassTake) begin
            writeEn   <= 1'b1;
            writeAddr <= memAddr;
            writeData <= memData;
            srcReg    <= WB_MEM;
        end else if (queuePop && headLive) begin
            writeEn   <= 1'b1;
            writeAddr <= headAddr;
            writeData <= headData;
            srcReg    <= WB_MEM;
        end else begin
            writeEn   <= 1'b0;
            srcReg    <= WB_NONE;
        end
    end

    assign writeSrc = srcReg;

endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback
//   Directed bench for reg_writeback: linear sequence of steps with
//   hand-computed expectations, one immediate assertion per comparison.
//   Inputs change 1 time unit after the rising edge; outputs are checked at
//   that same point, i.e. they reflect the edge just taken.
module tb_reg_writeback;

    logic        clk = 1'b0;
    logic        rstN;
    logic        aluValid;
    logic [3:0]  aluAddr;
    logic [7:0]  aluData;
    logic        memValid;
    logic        memReady;
    logic [3:0]  memAddr;
    logic [7:0]  memData;
    logic        writeEn;
    logic [3:0]  writeAddr;
    logic [7:0]  writeData;
    logic [1:0]  writeSrc;
    logic [15:0] pendingMask;
    logic [2:0]  queueCount;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_ALU  = 2'd1;
    localparam logic [1:0] SRC_MEM  = 2'd2;

    reg_writeback dut (
        .clk         (clk),
        .rstN        (rstN),
        .aluValid    (aluValid),
        .aluAddr     (aluAddr),
        .aluData     (aluData),
        .memValid    (memValid),
        .memReady    (memReady),
        .memAddr     (memAddr),
        .memData     (memData),
        .writeEn     (writeEn),
        .writeAddr   (writeAddr),
        .writeData   (writeData),
        .writeSrc    (writeSrc),
        .pendingMask (pendingMask),
        .queueCount  (queueCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkWrite(input string tag, input logic en, input logic [3:0] a,
                            input logic [7:0] d, input logic [1:0] src);
        chk({tag, ".en"}, 32'(writeEn), 32'(en));
        if (en) begin
            chk({tag, ".addr"}, 32'(writeAddr), 32'(a));
            chk({tag, ".data"}, 32'(writeData), 32'(d));
        end
        chk({tag, ".src"}, 32'(writeSrc), 32'(src));
        $display("step %-10s en=%0b addr=%0d data=%02h src=%0d count=%0d mask=%04h ready=%0b",
                 tag, writeEn, writeAddr, writeData, writeSrc, queueCount, pendingMask, memReady);
    endtask

    initial begin
        rstN = 1'b0; aluValid = 1'b0; aluAddr = '0; aluData = '0;
        memValid = 1'b0; memAddr = '0; memData = '0;
        tick(); tick();

        // Reset state
        chkWrite("reset", 1'b0, 4'd0, 8'h00, SRC_NONE);
        chk("reset.addr", 32'(writeAddr), 32'd0);
        chk("reset.data", 32'(writeData), 32'd0);
        chk("reset.count", 32'(queueCount), 32'd0);
        chk("reset.ready", 32'(memReady), 32'd1);
        chk("reset.mask", 32'(pendingMask), 32'd0);
        rstN = 1'b1;
        tick();

        // 1: single ALU write
        aluValid = 1'b1; aluAddr = 4'd3; aluData = 8'hA5;
        tick();
        chkWrite("alu1", 1'b1, 4'd3, 8'hA5, SRC_ALU);
        aluValid = 1'b0;
        tick();
        chkWrite("alu1idle", 1'b0, 4'd0, 8'h00, SRC_NONE);

        // 2: ALU busy 6 cycles while offering loads 1..5; only 4 fit
        for (int c = 1; c <= 6; c++) begin
            aluValid = 1'b1; aluAddr = 4'd15; aluData = 8'(8'hF0 + c);
            memValid = 1'b1;
            memAddr  = 4'((c <= 4) ? c : 5);
            memData  = 8'(8'h10 + ((c <= 4) ? c : 5));
            tick();
            chkWrite($sformatf("fill%0d", c), 1'b1, 4'd15, 8'(8'hF0 + c), SRC_ALU);
            chk($sformatf("fill%0d.count", c), 32'(queueCount), 32'((c < 4) ? c : 4));
        end
        chk("fill.ready", 32'(memReady), 32'd0);
        chk("fill.mask", 32'(pendingMask), 32'h001E);
        // ALU drops; load 5 still offered and accepted once a slot frees
        aluValid = 1'b0;
        tick();
        chkWrite("drain1", 1'b1, 4'd1, 8'h11, SRC_MEM);
        chk("drain1.count", 32'(queueCount), 32'd3);
        chk("drain1.ready", 32'(memReady), 32'd1);
        tick();
        chkWrite("drain2", 1'b1, 4'd2, 8'h12, SRC_MEM);
        chk("drain2.count", 32'(queueCount), 32'd3);
        memValid = 1'b0;
        for (int k = 3; k <= 5; k++) begin
            tick();
            chkWrite($sformatf("drain%0d", k), 1'b1, 4'(k), 8'(8'h10 + k), SRC_MEM);
            chk($sformatf("drain%0d.count", k), 32'(queueCount), 32'(5 - k));
        end
        tick();
        chkWrite("drainEnd", 1'b0, 4'd0, 8'h00, SRC_NONE);

        // 3: queued r7 squashed by later ALU r7
        aluValid = 1'b1; aluAddr = 4'd0; aluData = 8'h00;
        memValid = 1'b1; memAddr = 4'd7; memData = 8'h11;
        tick();
        chkWrite("sq.q", 1'b1, 4'd0, 8'h00, SRC_ALU);
        chk("sq.q.mask", 32'(pendingMask), 32'h0080);
        chk("sq.q.count", 32'(queueCount), 32'd1);
        memValid = 1'b0; aluAddr = 4'd7; aluData = 8'h22;
        tick();
        chkWrite("sq.alu", 1'b1, 4'd7, 8'h22, SRC_ALU);
        chk("sq.alu.mask", 32'(pendingMask), 32'h0000);
        chk("sq.alu.count", 32'(queueCount), 32'd1);
        aluValid = 1'b0;
        tick();
        chkWrite("sq.dead", 1'b0, 4'd0, 8'h00, SRC_NONE);
        chk("sq.dead.count", 32'(queueCount), 32'd0);
        tick();
        chkWrite("sq.idle", 1'b0, 4'd0, 8'h00, SRC_NONE);

        // 4: same-cycle ALU r2 and load r2
        aluValid = 1'b1; aluAddr = 4'd2; aluData = 8'h01;
        memValid = 1'b1; memAddr = 4'd2; memData = 8'h02;
        tick();
        chkWrite("same.alu", 1'b1, 4'd2, 8'h01, SRC_ALU);
        chk("same.count1", 32'(queueCount), 32'd1);
        chk("same.mask", 32'(pendingMask), 32'h0000);
        aluValid = 1'b0; memValid = 1'b0;
        tick();
        chkWrite("same.dead", 1'b0, 4'd0, 8'h00, SRC_NONE);
        chk("same.count0", 32'(queueCount), 32'd0);
        tick();
        chkWrite("same.idle", 1'b0, 4'd0, 8'h00, SRC_NONE);

        // 5: single load r9 into idle block
        memValid = 1'b1; memAddr = 4'd9; memData = 8'h3C;
        tick();
        memValid = 1'b0;
`ifdef REG_WRITEBACK_BYPASS_EN
        chkWrite("ld9.c1", 1'b1, 4'd9, 8'h3C, SRC_MEM);
        chk("ld9.c1.count", 32'(queueCount), 32'd0);
        tick();
        chkWrite("ld9.c2", 1'b0, 4'd0, 8'h00, SRC_NONE);
`else
        chkWrite("ld9.c1", 1'b0, 4'd0, 8'h00, SRC_NONE);
        chk("ld9.c1.count", 32'(queueCount), 32'd1);
        chk("ld9.c1.mask", 32'(pendingMask), 32'h0200);
        tick();
        chkWrite("ld9.c2", 1'b1, 4'd9, 8'h3C, SRC_MEM);
        chk("ld9.c2.count", 32'(queueCount), 32'd0);
`endif

        // 6: reset with 3 queued entries
        for (int k = 0; k < 3; k++) begin
            aluValid = 1'b1; aluAddr = 4'd0; aluData = 8'h55;
            memValid = 1'b1; memAddr = 4'(10 + k); memData = 8'(8'hC0 + k);
            tick();
        end
        chk("rq.count", 32'(queueCount), 32'd3);
        chk("rq.mask", 32'(pendingMask), 32'h1C00);
        aluValid = 1'b0; memValid = 1'b0;
        rstN = 1'b0;
        #1;
        chkWrite("rst.mid", 1'b0, 4'd0, 8'h00, SRC_NONE);
        chk("rst.mid.addr", 32'(writeAddr), 32'd0);
        chk("rst.mid.data", 32'(writeData), 32'd0);
        chk("rst.mid.count", 32'(queueCount), 32'd0);
        chk("rst.mid.ready", 32'(memReady), 32'd1);
        chk("rst.mid.mask", 32'(pendingMask), 32'd0);
        tick();
        rstN = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chkWrite($sformatf("post%0d", k), 1'b0, 4'd0, 8'h00, SRC_NONE);
            chk($sformatf("post%0d.count", k), 32'(queueCount), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Write-back arbiter that drives the register file's single write port from two result producers: the ALU (always accepted, highest priority) and the memory-load unit (valid/ready, buffered). Load results wait in a small in-order queue and drain into cycles the ALU leaves idle. Queued writes are squashed by any newer ALU write to the same register, so the file never sees a stale write. The block sits between execute/memory stages and the register file's `writeEn/writeAddr/writeData` inputs.

## Interface
- `DataWidth`, 8, register width
- `NumRegs`, 16, number of architectural registers
- `IndexWidth`, `$clog2(NumRegs)`, register index width
- `QueueDepth`, 4, load-result queue entries (power of two, ≥2)

- `clk`  in  1  clock, rising edge
- `rstN`  in  1  asynchronous active-low reset
- `aluValid`  in  1  ALU result present this cycle; always accepted
- `aluAddr`  in  IndexWidth  ALU destination register
- `aluData`  in  DataWidth  ALU result
- `memValid`  in  1  load result offered
- `memReady`  out  1  queue can accept; transfer when `memValid && memReady`
- `memAddr`  in  IndexWidth  load destination register
- `memData`  in  DataWidth  load result
- `writeEn`  out  1  register-file write enable (registered)
- `writeAddr`  out  IndexWidth  register-file write index (registered)
- `writeData`  out  DataWidth  register-file write data (registered)
- `writeSrc`  out  2  source of current write: NONE/ALU/MEM
- `pendingMask`  out  NumRegs  bit i set while a live queued write targets register i
- `queueCount`  out  $clog2(QueueDepth)+1  occupied entries

## Operation
- Queue entry = {live, addr, data}; FIFO order, head pointer, tail pointer, count.
- `memReady = (queueCount != QueueDepth)`; combinational from count only, independent of `memValid`.
- Each cycle, output-register load priority: ALU if `aluValid`; else queue head if count>0; else nothing (`writeEn`=0, `writeSrc`=NONE).
- Head entry popped whenever ALU idle and count>0. Dead head (live=0): popped with `writeEn`=0; costs one cycle.
- Squash: accepted ALU write to register r clears `live` on every queued entry with addr r the same cycle.
- Same-cycle ALU and accepted load to the same register: load is older; enqueued with live=0 (handshake completes, never written).
- Simultaneous push and pop: count unchanged; allowed when full (pop frees slot only next cycle — `memReady` stays 0 that cycle).
- Pointers wrap modulo QueueDepth.
- `pendingMask` = OR of one-hot(addr) over live entries; excludes the output register.
- Reset (any time, mid-drain included): queue emptied, all live bits cleared, `writeEn`=0, `writeAddr`=0, `writeData`=0, `writeSrc`=NONE, `pendingMask`=0, `queueCount`=0, hence `memReady`=1. In-flight loads are lost.

## Timing
- ALU result: write visible at register-file input 1 cycle after `aluValid` (registered output).
- Load result via queue: ≥2 cycles after handshake (enqueue, then pop to output register); +1 per ALU-busy cycle ahead of it.
- Continuous `aluValid` starves the queue; producers must tolerate unbounded `memReady`=0.
- `pendingMask` and `queueCount` update on the edge after the push/pop/squash.

## Configuration
- `REG_WRITEBACK_BYPASS_EN` defined: accepted load with queue empty and `aluValid`=0 loads the output register directly (1-cycle latency, not enqueued).
- Undefined: every load passes through the queue; minimum 2-cycle latency. All other behaviour identical.

## Structure
- Package `reg_writeback_pkg`: `wb_src_e` enum (NONE=0, ALU=1, MEM=2) and default parameter constants.
- Sub-module `wb_queue`: circular FIFO with per-entry live bit, address-match kill input, live-address mask output. Top level holds arbitration and output register.

## Test plan
- Reset, then `aluValid`=1, addr 3, data 8'hA5 for one cycle -> next cycle `writeEn`=1, `writeAddr`=3, `writeData`=8'hA5, `writeSrc`=ALU.
- `aluValid` held 1 for 6 cycles while pushing 5 loads (addrs 1–5) -> `memReady` falls to 0 after 4 accepted, `queueCount`=4; ALU drops -> loads 1–4 written in order on 4 consecutive cycles, then load 5.
- Queue load r7=8'h11, then ALU r7=8'h22 before drain -> r7 written only with 8'h22; dead entry drains with `writeEn`=0; `pendingMask[7]` clears on squash edge.
- Same cycle ALU r2=8'h01 and load r2=8'h02 -> only 8'h01 written; `queueCount` goes 1 then 0 with no MEM write.
- Single load r9=8'h3C into idle block -> written 1 cycle later with `REG_WRITEBACK_BYPASS_EN`, 2 cycles later without.
- Assert `rstN`=0 with 3 queued entries -> outputs immediately 0, `queueCount`=0, `memReady`=1; after release no stale writes appear.
